// File: rtl/ara_eoc_ctrl.sv
// End-of-computation controller: write-only register slave holding the tohost
// exit code and a software-controlled hardware cycle counter.
module ara_eoc_ctrl #(
  parameter int unsigned          AddrWidth = 64,
  parameter logic [AddrWidth-1:0] BaseAddr  = 64'hD000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [63:0]          w_data_i,
  input  logic [7:0]           w_strb_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [1:0]           b_resp_o,
  output logic [63:0]          exit_o,
  output logic [63:0]          runtime_o,
  output logic                 counting_o
);

  typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [63:0]          data_q, data_d;
  logic [7:0]           strb_q, strb_d;
  logic                 aw_ready_q, aw_ready_d;
  logic                 w_ready_q, w_ready_d;
  logic [1:0]           resp_q, resp_d;
  logic [63:0]          exit_q, exit_d;
  logic [63:0]          runtime_q, runtime_d;
  logic                 counting_q, counting_d;

  logic                 aw_fire, w_fire, commit;
  logic [AddrWidth-1:0] cm_addr;
  logic [63:0]          cm_data;
  logic [7:0]           cm_strb;
  logic                 hit, good;
  logic [1:0]           sel;
  logic                 unused_addr_bits;

  assign aw_fire = aw_valid_i & aw_ready_q;
  assign w_fire  = w_valid_i & w_ready_q;

  // The committing beat mixes whichever half was captured earlier with the live one.
  assign cm_addr = (state_q == HAVE_AW) ? addr_q : aw_addr_i;
  assign cm_data = (state_q == HAVE_W)  ? data_q : w_data_i;
  assign cm_strb = (state_q == HAVE_W)  ? strb_q : w_strb_i;

  assign hit  = (cm_addr[AddrWidth-1:5] == BaseAddr[AddrWidth-1:5]);
  assign sel  = cm_addr[4:3];
  assign good = hit && (sel != 2'd3) && (cm_strb == 8'hFF);
  assign unused_addr_bits = ^cm_addr[2:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_fire && w_fire) begin
          state_d = RESP;
          commit  = 1'b1;
        end else if (aw_fire) begin
          state_d = HAVE_AW;
          addr_d  = aw_addr_i;
        end else if (w_fire) begin
          state_d = HAVE_W;
          data_d  = w_data_i;
          strb_d  = w_strb_i;
        end
      end
      HAVE_AW: begin
        if (w_fire) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      HAVE_W: begin
        if (aw_fire) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready flags are registered from the next state so that no input reaches an output.
  assign aw_ready_d = (state_d == IDLE) || (state_d == HAVE_W);
  assign w_ready_d  = (state_d == IDLE) || (state_d == HAVE_AW);

  always_comb begin
    exit_d     = exit_q;
    counting_d = counting_q;
    runtime_d  = runtime_q;
    resp_d     = resp_q;
    if (counting_q && (runtime_q != '1)) runtime_d = runtime_q + 64'd1;
    if (commit) begin
      resp_d = good ? RespOkay : RespSlverr;
      if (good) begin
        unique case (sel)
          2'd0: begin
            if (cm_data[0] && !exit_q[0]) begin
              exit_d     = cm_data;
              counting_d = 1'b0;
              runtime_d  = runtime_q;
            end
          end
          2'd1: begin
            runtime_d  = '0;
            counting_d = 1'b1;
          end
          2'd2: begin
            counting_d = 1'b0;
            runtime_d  = runtime_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      resp_q     <= '0;
      exit_q     <= '0;
      runtime_q  <= '0;
      counting_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      resp_q     <= resp_d;
      exit_q     <= exit_d;
      runtime_q  <= runtime_d;
      counting_q <= counting_d;
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = (state_q == RESP);
  assign b_resp_o   = resp_q;
  assign exit_o     = exit_q;
  assign runtime_o  = runtime_q;
  assign counting_o = counting_q;

endmodule

// File: tb/tb_ara_eoc_ctrl.sv
// Randomized bench for ara_eoc_ctrl against a transaction-level register model.
module tb_ara_eoc_ctrl;

  localparam logic [63:0] BASE = 64'hD000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_valid = 1'b0;
  logic        aw_ready_o;
  logic [63:0] aw_addr = '0;
  logic        w_valid = 1'b0;
  logic        w_ready_o;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        b_valid_o;
  logic        b_ready = 1'b0;
  logic [1:0]  b_resp_o;
  logic [63:0] exit_o;
  logic [63:0] runtime_o;
  logic        counting_o;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  longint      ecount = 0;

  // Model: exit value, running flag, start edge, value held once stopped.
  logic [63:0] exit_m = '0;
  bit          cnt_m = 0;
  longint      t0_m = 0;
  longint      frozen_m = 0;

  ara_eoc_ctrl #(.AddrWidth(64), .BaseAddr(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready_o), .w_data_i(w_data), .w_strb_i(w_strb),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready), .b_resp_o(b_resp_o),
    .exit_o(exit_o), .runtime_o(runtime_o), .counting_o(counting_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_commit(input logic [63:0] addr, input logic [63:0] data,
                                              input logic [7:0] strb, input longint e);
    longint unsigned off;
    if (addr < BASE || addr >= BASE + 64'd32 || strb != 8'hFF) return 2'b10;
    off = (addr - BASE) / 8;
    case (off)
      0: if (data[0] == 1'b1 && exit_m[0] == 1'b0) begin
           if (cnt_m) frozen_m = e - t0_m - 1;
           exit_m = data;
           cnt_m  = 0;
         end
      1: begin cnt_m = 1; t0_m = e; end
      2: begin if (cnt_m) frozen_m = e - t0_m - 1; cnt_m = 0; end
      default: return 2'b10;
    endcase
    return 2'b00;
  endfunction

  function automatic logic [63:0] exp_rt();
    return cnt_m ? 64'(ecount - t0_m) : 64'(frozen_m);
  endfunction

  task automatic model_reset();
    exit_m = '0; cnt_m = 0; t0_m = 0; frozen_m = 0;
  endtask

  // Called and returning at a negedge; aw_at/w_at delay each channel by cycles.
  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int unsigned aw_at, input int unsigned w_at,
                          input int unsigned hold, output longint ce);
    bit aw_done = 0;
    bit w_done = 0;
    bit awf, wf;
    logic [1:0] er;
    int unsigned cyc = 0;
    ce = -1;
    aw_addr = addr; w_data = data; w_strb = strb; b_ready = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done) aw_valid = (cyc >= aw_at);
      if (!w_done)  w_valid  = (cyc >= w_at);
      vecs++;
      if (b_valid_o !== 1'b0) begin
        errs++; $display("FAIL early_bvalid: got %b want 0", b_valid_o);
      end
      awf = aw_valid && aw_ready_o;
      wf  = w_valid && w_ready_o;
      @(posedge clk); #1;
      if (awf) aw_done = 1;
      if (wf)  w_done = 1;
      if (aw_done && w_done) ce = ecount;
      @(negedge clk);
      if (aw_done) aw_valid = 1'b0;
      if (w_done)  w_valid = 1'b0;
      cyc++;
    end
    vecs++;
    if (ce < 0) begin
      errs++; $display("FAIL write_timeout: addr %h not accepted within 50 cycles", addr);
      aw_valid = 1'b0; w_valid = 1'b0;
      return;
    end
    er = model_commit(addr, data, strb, ce);
    vecs++;
    if (b_valid_o !== 1'b1) begin errs++; $display("FAIL b_valid: got %b want 1", b_valid_o); end
    vecs++;
    if (b_resp_o !== er) begin errs++; $display("FAIL b_resp: addr %h got %b want %b", addr, b_resp_o, er); end
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk);
      vecs++;
      if (b_valid_o !== 1'b1 || b_resp_o !== er || aw_ready_o !== 1'b0 || w_ready_o !== 1'b0) begin
        errs++;
        $display("FAIL b_hold: got valid %b resp %b awr %b wr %b want 1 %b 0 0",
                 b_valid_o, b_resp_o, aw_ready_o, w_ready_o, er);
      end
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    vecs++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1 || w_ready_o !== 1'b1) begin
      errs++;
      $display("FAIL b_done: got valid %b awr %b wr %b want 0 1 1", b_valid_o, aw_ready_o, w_ready_o);
    end
    vecs++;
    if (exit_o !== exit_m) begin errs++; $display("FAIL exit: got %h want %h", exit_o, exit_m); end
    vecs++;
    if (counting_o !== cnt_m) begin errs++; $display("FAIL counting: got %b want %b", counting_o, cnt_m); end
    vecs++;
    if (runtime_o !== exp_rt()) begin errs++; $display("FAIL runtime: got %0d want %0d", runtime_o, exp_rt()); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if (aw_ready_o !== 1'b0 || w_ready_o !== 1'b0 || b_valid_o !== 1'b0 || b_resp_o !== 2'b00 ||
        exit_o !== '0 || runtime_o !== '0 || counting_o !== 1'b0) begin
      errs++; $display("FAIL reset_values: awr %b wr %b bv %b resp %b exit %h rt %h cnt %b want all 0",
                       aw_ready_o, w_ready_o, b_valid_o, b_resp_o, exit_o, runtime_o, counting_o);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (aw_ready_o !== 1'b0 || w_ready_o !== 1'b0) begin
      errs++; $display("FAIL reset_ready: got %b %b want 0 0", aw_ready_o, w_ready_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (aw_ready_o !== 1'b1 || w_ready_o !== 1'b1) begin
      errs++; $display("FAIL post_reset_ready: got %b %b want 1 1", aw_ready_o, w_ready_o);
    end
    repeat (100) @(negedge clk);
    vecs++;
    if (runtime_o !== '0 || counting_o !== 1'b0 || exit_o !== '0) begin
      errs++; $display("FAIL idle_hold: rt %0d cnt %b exit %h want 0 0 0", runtime_o, counting_o, exit_o);
    end
  endtask

  task automatic test_runtime();
    longint t0, t1;
    do_write(BASE + 64'h08, {$urandom, $urandom}, 8'hFF, 0, 0, 0, t0);
    while (ecount < t0 + 9) begin
      @(negedge clk);
      vecs++;
      if (counting_o !== 1'b1) begin errs++; $display("FAIL counting_run: got %b want 1", counting_o); end
    end
    do_write(BASE + 64'h10, {$urandom, $urandom}, 8'hFF, 0, 0, 0, t1);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      vecs++;
      if (runtime_o !== 64'd9) begin errs++; $display("FAIL runtime_frozen: got %0d want 9", runtime_o); end
    end
  endtask

  task automatic test_fail_exit();
    longint t;
    do_write(BASE + 64'h08, '0, 8'hFF, 0, 0, 0, t);
    repeat ($urandom_range(5, 20)) @(negedge clk);
    do_write(BASE, 64'h2B, 8'hFF, 1, 0, 0, t);
    vecs++;
    if (exit_o !== 64'h2B || counting_o !== 1'b0) begin
      errs++; $display("FAIL fail_exit: exit %h cnt %b want 2b 0", exit_o, counting_o);
    end
    repeat (20) @(negedge clk);
    vecs++;
    if (runtime_o !== exp_rt()) begin errs++; $display("FAIL exit_freeze: got %0d want %0d", runtime_o, exp_rt()); end
  endtask

  task automatic test_tohost();
    longint t;
    do_write(BASE, 64'h1, 8'hFF, 0, 3, 0, t);
    vecs++;
    if (exit_o !== 64'h1) begin errs++; $display("FAIL tohost_exit: got %h want 1", exit_o); end
    do_write(BASE, 64'h5, 8'hFF, 0, 0, 0, t);
    vecs++;
    if (exit_o !== 64'h1) begin errs++; $display("FAIL tohost_sticky: got %h want 1", exit_o); end
  endtask

  task automatic test_errors();
    longint t;
    do_write(BASE + 64'h08, '0, 8'hFF, 0, 0, 0, t);
    do_write(BASE + 64'h18, 64'h3, 8'hFF, 0, 0, 5, t);
    do_write(BASE + 64'h10, 64'h0, 8'h0F, 2, 0, 0, t);
    do_write(BASE + 64'h40, 64'h7, 8'hFF, 0, 1, 2, t);
    vecs++;
    if (counting_o !== 1'b1) begin errs++; $display("FAIL err_nochange: counting %b want 1", counting_o); end
  endtask

  task automatic test_random();
    longint t;
    logic [63:0] a;
    logic [7:0]  s;
    int unsigned r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 64'(8 * $urandom_range(0, 3)) + 64'($urandom_range(0, 7));
      else if (r == 7) a = BASE + 64'h40 + 64'($urandom_range(0, 31));
      else if (r == 8) a = BASE - 64'(8 * $urandom_range(1, 4));
      else             a = {$urandom, $urandom};
      s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      do_write(a, {$urandom, $urandom}, s, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    longint t;
    bit wf;
    logic [1:0] er;
    do_write(BASE + 64'h08, '0, 8'hFF, 0, 0, 0, t);
    do_write(BASE, 64'h9, 8'hFF, 0, 0, 0, t);
    do_write(BASE + 64'h08, '0, 8'hFF, 0, 0, 0, t);
    aw_addr = BASE + 64'h10; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    vecs++;
    if (aw_ready_o !== 1'b0 || w_ready_o !== 1'b1 || counting_o !== 1'b1 || exit_o !== 64'h9) begin
      errs++; $display("FAIL have_aw: awr %b wr %b cnt %b exit %h want 0 1 1 9",
                       aw_ready_o, w_ready_o, counting_o, exit_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (aw_ready_o !== 1'b0 || w_ready_o !== 1'b0 || b_valid_o !== 1'b0 || b_resp_o !== 2'b00 ||
        exit_o !== '0 || runtime_o !== '0 || counting_o !== 1'b0) begin
      errs++; $display("FAIL async_reset: awr %b wr %b bv %b resp %b exit %h rt %h cnt %b want all 0",
                       aw_ready_o, w_ready_o, b_valid_o, b_resp_o, exit_o, runtime_o, counting_o);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w_data = 64'h1; w_strb = 8'hFF; w_valid = 1'b1;
    wf = 0;
    for (int i = 0; i < 10 && !wf; i++) begin
      wf = w_ready_o;
      @(negedge clk);
    end
    w_valid = 1'b0;
    vecs++;
    if (!wf) begin errs++; $display("FAIL w_alone_timeout: w not accepted"); end
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (b_valid_o !== 1'b0 || exit_o !== '0 || aw_ready_o !== 1'b1 || w_ready_o !== 1'b0) begin
        errs++; $display("FAIL have_w: bv %b exit %h awr %b wr %b want 0 0 1 0",
                         b_valid_o, exit_o, aw_ready_o, w_ready_o);
      end
    end
    aw_addr = BASE; aw_valid = 1'b1;
    @(posedge clk); #1;
    t = ecount;
    @(negedge clk);
    aw_valid = 1'b0;
    er = model_commit(BASE, 64'h1, 8'hFF, t);
    vecs++;
    if (b_valid_o !== 1'b1 || b_resp_o !== er || exit_o !== exit_m) begin
      errs++; $display("FAIL w_first_commit: bv %b resp %b exit %h want 1 %b %h", b_valid_o, b_resp_o, exit_o, er, exit_m);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_runtime();
    test_fail_exit();
    apply_reset();
    test_tohost();
    test_errors();
    apply_reset();
    test_random();
    apply_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
